// File: rtl/cpu_pkg.sv
// Shared next-PC select and jump-kind codes for pc_unit and control_unit.
// No ports; constants only.
package cpu_pkg;

    localparam logic [2:0] PCS_INC = 3'b000;
    localparam logic [2:0] PCS_BR  = 3'b010;
    localparam logic [2:0] PCS_ILL = 3'b100;
    localparam logic [2:0] PCS_JMP = 3'b110;

    localparam logic [1:0] JK_JMP = 2'b00;
    localparam logic [1:0] JK_JSR = 2'b01;
    localparam logic [1:0] JK_RTS = 2'b11;

endpackage

// File: rtl/pc_unit_if.sv
// Control/status bundle between control_unit (master) and pc_unit (slave).
// Inputs: pc_en, pcsrc, jkind, offset, target, clr_err; status back: pc, stack state, flags.
interface pc_unit_if #(
    parameter int PC_W  = 8,
    parameter int OFF_W = 6,
    parameter int DW    = 3
);
    logic             pc_en;
    logic [2:0]       pcsrc;
    logic [1:0]       jkind;
    logic [OFF_W-1:0] offset;
    logic [PC_W-1:0]  target;
    logic             clr_err;
    logic [PC_W-1:0]  pc;
    logic [PC_W-1:0]  pc_plus1;
    logic [DW-1:0]    depth;
    logic             empty;
    logic             full;
    logic             ovf;
    logic             unf;
    logic             illegal;

    modport master (
        output pc_en, pcsrc, jkind, offset, target, clr_err,
        input  pc, pc_plus1, depth, empty, full, ovf, unf, illegal
    );

    modport slave (
        input  pc_en, pcsrc, jkind, offset, target, clr_err,
        output pc, pc_plus1, depth, empty, full, ovf, unf, illegal
    );
endinterface

// File: rtl/ret_stack.sv
// Circular return-address stack: DEPTH x PC_W, newest entry at ptr-1.
// Ports: push/pop/din in; top, depth, full, empty, ovf_evt, unf_evt out.
module ret_stack #(
    parameter int PC_W  = 8,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH),
    parameter int DW    = AW + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  logic            pop,
    input  logic [PC_W-1:0] din,
    output logic [PC_W-1:0] top,
    output logic [DW-1:0]   depth,
    output logic            full,
    output logic            empty,
    output logic            ovf_evt,
    output logic            unf_evt
);

    logic [PC_W-1:0] mem [DEPTH];
    logic [AW-1:0]   ptr;
    logic [DW-1:0]   cnt;

    assign depth   = cnt;
    assign full    = (cnt == DW'(DEPTH));
    assign empty   = (cnt == '0);
    assign top     = mem[ptr - AW'(1)];
    assign ovf_evt = push & full;
    assign unf_evt = pop & empty;

    // Contents are don't-care after reset, so the array has no reset.
    always_ff @(posedge clk) begin
        if (push)
            mem[ptr] <= din;
    end

    // A push while full overwrites the oldest slot: the pointer still
    // advances but the count saturates at DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
            cnt <= '0;
        end else if (push) begin
            ptr <= ptr + AW'(1);
            if (!full)
                cnt <= cnt + DW'(1);
        end else if (pop && !empty) begin
            ptr <= ptr - AW'(1);
            cnt <= cnt - DW'(1);
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Program counter stage: next-PC mux, PC register, return stack, sticky errors.
// Ports: clk, rst_n, bus (pc_unit_if.slave) carrying controls in and PC/status out.
module pc_unit
    import cpu_pkg::*;
#(
    parameter int PC_W      = 8,
    parameter int OFF_W     = 6,
    parameter int DEPTH     = 4,
    parameter int RESET_VEC = 0,
    parameter int DW        = $clog2(DEPTH) + 1
) (
    input  logic       clk,
    input  logic       rst_n,
    pc_unit_if.slave   bus
);

    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] pc_nxt;
    logic [PC_W-1:0] sext_off;
    logic [PC_W-1:0] top;
    logic [DW-1:0]   depth;
    logic            is_jsr;
    logic            is_rts;
    logic            ill_evt;
    logic            push;
    logic            pop;
    logic            full;
    logic            empty;
    logic            ovf_evt;
    logic            unf_evt;
    logic            ovf_q;
    logic            unf_q;
    logic            ill_q;

    assign pc_inc   = pc_q + PC_W'(1);
    assign sext_off = {{(PC_W-OFF_W){bus.offset[OFF_W-1]}}, bus.offset};

    always_comb begin
        pc_nxt  = pc_inc;
        is_jsr  = 1'b0;
        is_rts  = 1'b0;
        ill_evt = 1'b0;
        unique case (bus.pcsrc)
            PCS_INC, PCS_INC | 3'b001: pc_nxt = pc_inc;
            PCS_BR,  PCS_BR  | 3'b001: pc_nxt = pc_q + sext_off;
            PCS_ILL, PCS_ILL | 3'b001: ill_evt = 1'b1;
            PCS_JMP, PCS_JMP | 3'b001: begin
                unique case (bus.jkind)
                    JK_JMP: pc_nxt = bus.target;
                    JK_JSR: begin
                        is_jsr = 1'b1;
                        pc_nxt = bus.target;
                    end
                    JK_RTS: begin
                        is_rts = 1'b1;
                        // Underflowing return falls through to pc+1.
                        pc_nxt = empty ? pc_inc : top;
                    end
                    default: ill_evt = 1'b1;
                endcase
            end
            default: ill_evt = 1'b1;
        endcase
    end

    assign push = bus.pc_en & is_jsr;
    assign pop  = bus.pc_en & is_rts;

    ret_stack #(
        .PC_W  (PC_W),
        .DEPTH (DEPTH)
    ) u_stack (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .pop     (pop),
        .din     (pc_inc),
        .top     (top),
        .depth   (depth),
        .full    (full),
        .empty   (empty),
        .ovf_evt (ovf_evt),
        .unf_evt (unf_evt)
    );

    // Clear is honoured even while stalled; a same-cycle event wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q  <= PC_W'(RESET_VEC);
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
            ill_q <= 1'b0;
        end else begin
            if (bus.pc_en)
                pc_q <= pc_nxt;
            ovf_q <= (ovf_q & ~bus.clr_err) | ovf_evt;
            unf_q <= (unf_q & ~bus.clr_err) | unf_evt;
            ill_q <= (ill_q & ~bus.clr_err) | (bus.pc_en & ill_evt);
        end
    end

    assign bus.pc       = pc_q;
    assign bus.pc_plus1 = pc_inc;
    assign bus.depth    = depth;
    assign bus.empty    = empty;
    assign bus.full     = full;
    assign bus.ovf      = ovf_q;
    assign bus.unf      = unf_q;
    assign bus.illegal  = ill_q;

endmodule
